// File: rtl/nn_class_argmax.sv
// Output-layer argmax: regenerates the neuron-layer valid strobe through a
// fixed delay line, captures the layer outputs and serially scans for the winner.
module nn_class_argmax #(
  parameter int N_OUT    = 7,
  parameter int W        = 17,
  parameter int PIPE_LAT = 6,
  parameter int IDXW     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [N_OUT*W-1:0] y_bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDXW-1:0]    class_idx,
  output logic [W-1:0]       class_score,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_overrun
);

  // Handshake: a result transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid, class_idx and class_score hold stable
  // until then, and out_valid never drops without a transfer except on reset.

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N_OUT - 1);
  localparam logic [IDXW-1:0] FIRST_CNT = IDXW'((N_OUT > 1) ? 1 : 0);

  state_t              state;
  logic [PIPE_LAT-1:0] vld_sr;
  logic                vld_d;
  logic [W-1:0]        ybuf [N_OUT];
  logic [W-1:0]        best_score;
  logic [IDXW-1:0]     best_idx;
  logic [IDXW-1:0]     cnt;
  logic [W-1:0]        cur;
  logic                cur_wins;
  logic                last;
  logic                xfer;
  logic                capture;
  logic                drop;

  assign vld_d = vld_sr[PIPE_LAT-1];

  // Free-running strobe delay matching the neuron pipeline latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      for (int i = 1; i < PIPE_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (cnt == IDXW'(i)) cur = ybuf[i];
    end
  end

  assign cur_wins = (cur > best_score);
  assign last     = (cnt == LAST_IDX);
  assign xfer     = (state == DONE) && out_ready;
  assign capture  = vld_d && ((state == IDLE) || xfer);
  assign drop     = vld_d && ((state == SCAN) || ((state == DONE) && !out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      for (int i = 0; i < N_OUT; i++) ybuf[i] <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      busy        <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < N_OUT; i++) ybuf[i] <= y_bus[i*W +: W];
      best_score <= y_bus[W-1:0];
      best_idx   <= '0;
      cnt        <= FIRST_CNT;
      busy       <= 1'b1;
      if (N_OUT == 1) begin
        state       <= DONE;
        out_valid   <= 1'b1;
        class_idx   <= '0;
        class_score <= y_bus[W-1:0];
      end else begin
        state       <= SCAN;
        out_valid   <= 1'b0;
        class_idx   <= '0;
        class_score <= '0;
      end
    end else if (xfer) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      busy        <= 1'b0;
    end else if (state == SCAN) begin
      // Strict compare keeps the earlier index on ties.
      if (cur_wins) begin
        best_score <= cur;
        best_idx   <= cnt;
      end
      if (last) begin
        state       <= DONE;
        cnt         <= '0;
        out_valid   <= 1'b1;
        class_idx   <= cur_wins ? cnt : best_idx;
        class_score <= cur_wins ? cur : best_score;
      end else begin
        cnt <= cnt + IDXW'(1);
      end
    end
  end

  // Set beats clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule
